// File: rtl/vt_event_scheduler.sv
// rtl/vt_event_scheduler.sv - virtual-time event scheduler: in-order FIFO released when virtual_time reaches each timestamp
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   virtual_time      current virtual time
//   flush             synchronous clear of buffered and presented events
//   in_valid/in_ready/in_time/in_data      timestamped event input
//   out_valid/out_ready/out_time/out_data  due event output
//   out_late          presented event was loaded after its due time
//   count             FIFO occupancy, output stage excluded
module vt_event_scheduler #(
  parameter int TIME_SCALE_WIDTH = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int DEPTH            = 8,
  parameter int CNT_WIDTH        = $clog2(DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [TIME_SCALE_WIDTH-1:0] virtual_time,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [TIME_SCALE_WIDTH-1:0] in_time,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [TIME_SCALE_WIDTH-1:0] out_time,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_late,
  output logic [CNT_WIDTH-1:0]        count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

  logic [TIME_SCALE_WIDTH-1:0] mem_time_q [DEPTH];
  logic [TIME_SCALE_WIDTH-1:0] mem_time_d [DEPTH];
  logic [DATA_WIDTH-1:0]       mem_data_q [DEPTH];
  logic [DATA_WIDTH-1:0]       mem_data_d [DEPTH];
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]        count_q, count_d;
  logic                        out_valid_q, out_valid_d;
  logic [TIME_SCALE_WIDTH-1:0] out_time_q, out_time_d;
  logic [DATA_WIDTH-1:0]       out_data_q, out_data_d;
  logic                        out_late_q, out_late_d;

  logic [TIME_SCALE_WIDTH-1:0] head_time;
  logic [TIME_SCALE_WIDTH-1:0] diff;
  logic                        head_due;
  logic                        fifo_empty;
  logic                        push;
  logic                        load;

  assign in_ready   = (count_q != FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign head_time  = mem_time_q[rd_ptr_q];
  // Modular distance from the head timestamp to now; MSB clear means the
  // timestamp lies in the past half of the time circle, i.e. it is due.
  assign diff       = virtual_time - head_time;
  assign head_due   = ~diff[TIME_SCALE_WIDTH-1];
  assign push       = in_valid && in_ready;
  assign load       = !fifo_empty && head_due && (!out_valid_q || out_ready);

  assign out_valid = out_valid_q;
  assign out_time  = out_time_q;
  assign out_data  = out_data_q;
  assign out_late  = out_late_q;
  assign count     = count_q;

  always_comb begin
    mem_time_d  = mem_time_q;
    mem_data_d  = mem_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_time_d  = out_time_q;
    out_data_d  = out_data_q;
    out_late_d  = out_late_q;

    if (flush) begin
      // Flush wins over any same-cycle push or pop.
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
      out_late_d  = 1'b0;
    end else begin
      if (push) begin
        mem_time_d[wr_ptr_q] = in_time;
        mem_data_d[wr_ptr_q] = in_data;
        wr_ptr_d             = wr_ptr_q + 1'b1;
      end
      // Only the stored head can load, so a push into an empty FIFO
      // never bypasses straight to the output stage.
      if (load) begin
        rd_ptr_d    = rd_ptr_q + 1'b1;
        out_valid_d = 1'b1;
        out_time_d  = head_time;
        out_data_d  = mem_data_q[rd_ptr_q];
        out_late_d  = (diff != '0);
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
      case ({push, load})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_time_q[i] <= '0;
        mem_data_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_time_q  <= '0;
      out_data_q  <= '0;
      out_late_q  <= 1'b0;
    end else begin
      mem_time_q  <= mem_time_d;
      mem_data_q  <= mem_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_time_q  <= out_time_d;
      out_data_q  <= out_data_d;
      out_late_q  <= out_late_d;
    end
  end

endmodule

// File: tb/tb_vt_event_scheduler.sv
// tb/tb_vt_event_scheduler.sv - self-checking bench for vt_event_scheduler
module tb_vt_event_scheduler;

  localparam int TW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [TW-1:0] vt = '0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [TW-1:0] in_time = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [TW-1:0] out_time;
  logic [DW-1:0] out_data;
  logic          out_late;
  logic [CW-1:0] count;

  vt_event_scheduler #(
    .TIME_SCALE_WIDTH(TW),
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .virtual_time(vt),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_time(in_time),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_time(out_time),
    .out_data(out_data),
    .out_late(out_late),
    .count(count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of pending events plus the one
  // presented event, advanced once per clock from the sampled inputs.
  typedef struct {
    logic [TW-1:0] t;
    logic [DW-1:0] d;
  } ev_t;

  ev_t           mq[$];
  ev_t           m_head;
  logic          m_valid;
  logic [TW-1:0] m_time;
  logic [DW-1:0] m_data;
  logic          m_late;
  logic [TW-1:0] m_lag;
  bit            m_acc;
  bit            m_ld;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_valid = 1'b0;
      m_time  = '0;
      m_data  = '0;
      m_late  = 1'b0;
    end else if (flush) begin
      mq.delete();
      m_valid = 1'b0;
      m_late  = 1'b0;
    end else begin
      m_acc = in_valid && (mq.size() != DEPTH);
      m_ld  = 1'b0;
      if (mq.size() > 0) begin
        m_lag = vt - mq[0].t;
        m_ld  = (m_lag < 32'h8000_0000) && (!m_valid || out_ready);
      end
      if (m_ld) begin
        m_head  = mq.pop_front();
        m_valid = 1'b1;
        m_time  = m_head.t;
        m_data  = m_head.d;
        m_late  = (vt != m_head.t);
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      if (m_acc) mq.push_back('{t: in_time, d: in_data});
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("mdl_in_ready", in_ready, (mq.size() != DEPTH));
      check("mdl_count", count, mq.size());
      check("mdl_out_valid", out_valid, m_valid);
      if (m_valid) begin
        check("mdl_out_time", out_time, m_time);
        check("mdl_out_data", out_data, m_data);
        check("mdl_out_late", out_late, m_late);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [TW-1:0] t, input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_time  = t;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_time"}, out_time, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_late"}, out_late, 0);
    check({tag, "_count"}, count, 0);
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  logic [TW-1:0] nt;

  initial begin
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    step();

    // Future event fires one cycle after its time is sampled.
    vt = 10;
    out_ready = 1'b1;
    push(100, 32'hA5);
    check("t1_count_after_push", count, 1);
    vt = 99;
    step();
    check("t1_not_yet", out_valid, 0);
    vt = 100;
    step();
    check("t1_valid", out_valid, 1);
    check("t1_time", out_time, 100);
    check("t1_data", out_data, 32'hA5);
    check("t1_late", out_late, 0);
    step();
    check("t1_drained", out_valid, 0);
    check("t1_count", count, 0);

    // Late events stream on consecutive cycles in push order.
    vt = 200;
    push(50, 1);
    check("t2_no_bypass", out_valid, 0);
    in_valid = 1'b1; in_time = 50; in_data = 2;
    step();
    check("t2_first", out_data, 1);
    check("t2_first_late", out_late, 1);
    in_data = 3;
    step();
    check("t2_second", out_data, 2);
    in_valid = 1'b0;
    step();
    check("t2_third", out_data, 3);
    check("t2_third_late", out_late, 1);
    step();
    check("t2_done", out_valid, 0);

    // Fill to DEPTH; full blocks further pushes until a pop.
    vt = 0;
    for (int i = 0; i < DEPTH; i++) push(1000, 32'h300 + i);
    check("t3_full_count", count, DEPTH);
    check("t3_full_ready", in_ready, 0);
    in_valid = 1'b1; in_time = 1000; in_data = 32'h399;
    step();
    check("t3_ninth_rejected", count, DEPTH);
    vt = 1000;
    step();
    check("t3_ready_after_pop", in_ready, 1);
    check("t3_count_after_pop", count, DEPTH - 1);
    in_valid = 1'b0;
    repeat (10) step();
    check("t3_empty", count, 0);

    // Backpressure holds the presented event stable.
    vt = 2000;
    out_ready = 1'b0;
    push(2000, 32'h11);
    push(2000, 32'h22);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_hold_valid", out_valid, 1);
      check("t4_hold_data", out_data, 32'h11);
      check("t4_hold_time", out_time, 2000);
      check("t4_hold_late", out_late, 0);
      check("t4_hold_count", count, 1);
    end
    out_ready = 1'b1;
    step();
    check("t4_next", out_data, 32'h22);
    step();
    check("t4_done", out_valid, 0);

    // Timestamp across virtual_time wrap.
    vt = 32'hFFFF_FFF0;
    push(5, 32'h55);
    for (int k = 1; k <= 21; k++) begin
      vt = 32'hFFFF_FFF0 + TW'(k);
      step();
      check("t5_wrap_valid", out_valid, (vt == 5));
    end
    check("t5_wrap_data", out_data, 32'h55);
    check("t5_wrap_late", out_late, 0);
    step();

    // Flush beats a same-cycle push.
    vt = 3000;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(3000, 32'h600 + i);
    check("t6_count_before", count, 4);
    check("t6_valid_before", out_valid, 1);
    flush = 1'b1; in_valid = 1'b1; in_time = 3000; in_data = 32'h6FF;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("t6_flush_count", count, 0);
    check("t6_flush_valid", out_valid, 0);
    check("t6_flush_late", out_late, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_push_discarded", out_valid, 0);
    end

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    push(3000, 32'h71);
    push(3000, 32'h72);
    check("t7_presented", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Randomized traffic against the model.
    vt = 32'h1000;
    nt = vt;
    for (int c = 0; c < 3000; c++) begin
      vt = vt + TW'((c < 1500) ? $urandom_range(0, 1) : $urandom_range(0, 2));
      in_valid = ($urandom_range(0, 99) < 45);
      if (in_valid) begin
        nt = nt + TW'($urandom_range(0, 3));
        in_time = nt;
        in_data = $urandom;
      end
      out_ready = ($urandom_range(0, 99) < 70);
      flush = ($urandom_range(0, 199) == 0);
      step();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vt_event_scheduler.md
Name: vt_event_scheduler

Overview:
Consumer of the emulator's free-running virtual time counter. Accepts timestamped events through a valid/ready input. Buffers them in order in a FIFO. Releases each event on a valid/ready output once virtual_time has reached the event's timestamp. Used to replay recorded stimulus into the emulated design at exact virtual-time instants.

Parameters:
TIME_SCALE_WIDTH, 32, width of virtual_time and of event timestamps
DATA_WIDTH, 32, width of the event payload
DEPTH, 8, FIFO entries; power of two, minimum 2
CNT_WIDTH, $clog2(DEPTH)+1, width of the occupancy count

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
virtual_time  input  TIME_SCALE_WIDTH  current virtual time from the time counter
flush  input  1  synchronous clear of all buffered and presented events
in_valid  input  1  event offered
in_ready  output  1  event slot available
in_time  input  TIME_SCALE_WIDTH  event due time
in_data  input  DATA_WIDTH  event payload
out_valid  output  1  due event presented
out_ready  input  1  downstream accepts event
out_time  output  TIME_SCALE_WIDTH  timestamp of presented event
out_data  output  DATA_WIDTH  payload of presented event
out_late  output  1  presented event was loaded after its due time
count  output  CNT_WIDTH  FIFO occupancy; excludes the output stage

Behaviour:
- Reset: rst_n is asynchronous, active-low; clk is the clock. On reset, FIFO is empty, in_ready=1 (when DEPTH>0), out_valid=0, out_time=0, out_data=0, out_late=0, count=0.
- Input push:
  - Push occurs when in_valid && in_ready.
  - in_ready = (count != DEPTH); it is registered-state derived only and never depends on out_ready.
  - Producer must supply non-decreasing timestamps (modulo wrap). The block does not reorder events.
- Due test:
  - diff = virtual_time - head_time, modulo 2^TIME_SCALE_WIDTH.
  - Head is due when diff[MSB]==0, i.e. 0 <= diff < 2^(W-1).
  - A timestamp more than 2^(W-1)-1 ticks in the future is therefore treated as past (late). This is a documented limitation.
- Output stage (single register):
  - Load condition: FIFO non-empty && head due && (out_valid==0 || out_ready==1).
  - On load: pop the head, and on the next cycle set out_valid=1, out_time=head_time, out_data=head_data, out_late=(diff!=0).
  - If out_valid && out_ready and nothing loads, clear out_valid next cycle.
  - out_* hold stable while out_valid && !out_ready.
  - Back-to-back events with equal timestamps stream at one per cycle when out_ready=1.
- Latency:
  - Event already buffered, virtual_time==T sampled at cycle n, output stage free: out_valid=1 at cycle n+1 with out_late=0.
  - Event pushed at cycle n whose time is already due: out_valid=1 at cycle n+2 at earliest, since the FIFO write is visible at n+1.
- Simultaneous push and pop:
  - Allowed in the same cycle; count is unchanged.
  - Pushing into an empty FIFO does not bypass to the output stage.
- Full: in_ready=0 while count==DEPTH, even if a pop occurs that cycle.
- Empty: no load; out_valid drains normally.
- Flush:
  - On the next edge, empties the FIFO, clears out_valid and out_late, and sets count=0.
  - Takes priority over a same-cycle push or pop; the pushed event is discarded.
- Pointers: read and write pointers are log2(DEPTH) bits and wrap naturally.
- Reset mid-operation: all buffered and presented events are lost; outputs return to reset values asynchronously.
- virtual_time wrap: an event with T=0 pushed while virtual_time=0xFFFF_FFFE fires when virtual_time=0x0000_0000, with out_late=0.

Test Plan:
1. Push (T=100, D=0xA5) at vt=10; hold out_ready=1 -> out_valid rises exactly one cycle after vt=100 is sampled; out_time=100, out_data=0xA5, out_late=0; count returns to 0.
2. Push 3 events with T=50 at vt=200 -> out_late=1 for all; they stream on 3 consecutive cycles, in push order.
3. Push DEPTH=8 events with T=1000 at vt=0 -> in_ready=0 after the 8th push and count=8; a 9th in_valid is not accepted. Once vt reaches 1000, with out_ready=1, in_ready re-asserts after the first pop.
4. Set out_ready=0 while an event is presented -> out_time, out_data and out_late stay stable for 5 cycles; the next due event waits in the FIFO. Raising out_ready hands over on consecutive cycles.
5. Wrap case: vt=0xFFFF_FFF0, push T=0x0000_0005 -> no output until vt=5, then out_late=0.
6. With 4 buffered events and one presented, pulse flush together with in_valid -> next cycle count=0, out_valid=0, and the pushed event is absent. A separate run asserting rst_n=0 mid-stream shows all outputs at reset values immediately.
